// File: rtl/data_cache_pkg.sv
// Shared types and address-field helpers for the data cache.
// Field widths are derived from the SETS/BLOCK_WORDS parameters.
package data_cache_pkg;

  localparam int DefSets       = 64;
  localparam int DefWays       = 2;
  localparam int DefBlockWords = 4;

  typedef enum logic [1:0] {
    LOOKUP,
    WRITEBACK,
    REFILL
  } cacheState_t;

  function automatic int offBits(input int words);
    return (words > 1) ? $clog2(words) : 0;
  endfunction

  function automatic int idxBits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagBits(input int sets, input int words);
    return 30 - offBits(words) - idxBits(sets);
  endfunction

  // Word counter is at least one bit wide even for one-word lines
  function automatic int cntBits(input int words);
    return (offBits(words) > 0) ? offBits(words) : 1;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: valid/dirty status, tag and data storage.
// Status bits reset asynchronously; tag and data arrays do not.
module cache_way
  import data_cache_pkg::*;
#(
  parameter int SETS        = DefSets,
  parameter int BLOCK_WORDS = DefBlockWords,
  localparam int IW = idxBits(SETS),
  localparam int TW = tagBits(SETS, BLOCK_WORDS),
  localparam int CW = cntBits(BLOCK_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] idx,
  input  logic [CW-1:0] word,
  input  logic          wrEn,
  input  logic [31:0]   wrData,
  input  logic [3:0]    wrStrb,
  input  logic          markDirty,
  input  logic          fillDone,
  input  logic [TW-1:0] fillTag,
  output logic          rdValid,
  output logic          rdDirty,
  output logic [TW-1:0] rdTag,
  output logic [31:0]   rdData
);

  logic [SETS-1:0] validBits;
  logic [SETS-1:0] dirtyBits;
  logic [TW-1:0]   tagMem  [SETS];
  logic [31:0]     dataMem [SETS][BLOCK_WORDS];

  assign rdValid = validBits[idx];
  assign rdDirty = dirtyBits[idx];
  assign rdTag   = tagMem[idx];
  assign rdData  = dataMem[idx][word];

  // Line status: fill completion validates, store hit dirties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validBits <= '0;
      dirtyBits <= '0;
    end else if (fillDone) begin
      validBits[idx] <= 1'b1;
      dirtyBits[idx] <= 1'b0;
    end else if (markDirty) begin
      dirtyBits[idx] <= 1'b1;
    end
  end

  // Tag and byte-strobed data writes
  always_ff @(posedge clk) begin
    if (fillDone) tagMem[idx] <= fillTag;
    if (wrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (wrStrb[b])
          dataMem[idx][word][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Blocking write-back data cache, 1 or 2 ways, LRU replacement.
// Misses stall the pipeline while a line is written back and refilled.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int SETS        = DefSets,
  parameter int WAYS        = DefWays,
  parameter int BLOCK_WORDS = DefBlockWords
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int OB = offBits(BLOCK_WORDS);
  localparam int IW = idxBits(SETS);
  localparam int TW = tagBits(SETS, BLOCK_WORDS);
  localparam int CW = cntBits(BLOCK_WORDS);
  localparam logic [CW-1:0] LastWord = CW'(BLOCK_WORDS - 1);

  cacheState_t   state;
  logic [CW-1:0] count;
  logic [TW-1:0] capTag;
  logic [IW-1:0] capIdx;
  logic          capWay;
  logic [SETS-1:0] lru;

  logic [TW-1:0] reqTag;
  logic [IW-1:0] reqIdx;
  logic [CW-1:0] reqWord;
  logic          unusedBits;

  assign reqTag     = req_addr[31 -: TW];
  assign reqIdx     = req_addr[OB+2 +: IW];
  assign reqWord    = req_addr[2 +: CW] & LastWord;
  assign unusedBits = ^req_addr[1:0];

  logic          inLookup;
  logic [IW-1:0] wayIdx;
  logic [CW-1:0] wayWord;

  assign inLookup = (state == LOOKUP);
  assign wayIdx   = inLookup ? reqIdx : capIdx;
  assign wayWord  = inLookup ? reqWord : count;

  logic [WAYS-1:0] wayValid, wayDirty, wayHit;
  logic [WAYS-1:0] wayWr, wayMark, wayFill;
  logic [TW-1:0]   wayTag  [WAYS];
  logic [31:0]     wayData [WAYS];
  logic [31:0]     wrData;
  logic [3:0]      wrStrb;

  for (genvar w = 0; w < WAYS; w++) begin : gWay
    cache_way #(
      .SETS       (SETS),
      .BLOCK_WORDS(BLOCK_WORDS)
    ) uWay (
      .clk      (clk),
      .rst      (rst),
      .idx      (wayIdx),
      .word     (wayWord),
      .wrEn     (wayWr[w]),
      .wrData   (wrData),
      .wrStrb   (wrStrb),
      .markDirty(wayMark[w]),
      .fillDone (wayFill[w]),
      .fillTag  (capTag),
      .rdValid  (wayValid[w]),
      .rdDirty  (wayDirty[w]),
      .rdTag    (wayTag[w]),
      .rdData   (wayData[w])
    );
    assign wayHit[w] = wayValid[w] && (wayTag[w] == reqTag);
  end

  logic anyHit, hitWay, victim;

  assign anyHit = inLookup && (|wayHit);

  if (WAYS == 2) begin : gTwo
    assign hitWay = wayHit[1];
    assign victim = !wayValid[0] ? 1'b0 :
                    !wayValid[1] ? 1'b1 : lru[reqIdx];
  end else begin : gOne
    assign hitWay = 1'b0;
    assign victim = 1'b0;
  end

  logic [31:0]   hitData, vicData;
  logic [TW-1:0] vicTag;
  logic          vicDirty;

  // Way selection for hit data, miss victim and write-back source
  always_comb begin
    hitData  = '0;
    vicData  = '0;
    vicTag   = '0;
    vicDirty = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (wayHit[w]) hitData = wayData[w];
      if (victim == 1'(w))
        vicDirty = wayValid[w] && wayDirty[w];
      if (capWay == 1'(w)) begin
        vicData = wayData[w];
        vicTag  = wayTag[w];
      end
    end
  end

  // Per-way write enables: store hits and refill words
  always_comb begin
    wrData  = inLookup ? req_wdata : mem_rdata;
    wrStrb  = inLookup ? req_wstrb : 4'hF;
    wayWr   = '0;
    wayMark = '0;
    wayFill = '0;
    for (int w = 0; w < WAYS; w++) begin
      wayMark[w] = inLookup && req_valid &&
                   req_write && wayHit[w];
      wayWr[w]   = wayMark[w] ||
                   ((state == REFILL) && mem_ready &&
                    (capWay == 1'(w)));
      wayFill[w] = (state == REFILL) && mem_ready &&
                   (capWay == 1'(w)) && (count == LastWord);
    end
  end

  // Miss FSM: capture request, write back dirty victim, refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= LOOKUP;
      count  <= '0;
      capTag <= '0;
      capIdx <= '0;
      capWay <= 1'b0;
    end else begin
      unique case (state)
        LOOKUP: begin
          if (req_valid && !anyHit) begin
            capTag <= reqTag;
            capIdx <= reqIdx;
            capWay <= victim;
            count  <= '0;
            state  <= vicDirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            if (count == LastWord) begin
              count <= '0;
              state <= REFILL;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        REFILL: begin
          if (mem_ready) begin
            if (count == LastWord) begin
              count <= '0;
              state <= LOOKUP;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        default: state <= LOOKUP;
      endcase
    end
  end

  // LRU points at the way not used by the latest hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lru <= '0;
    else if (WAYS == 2 && anyHit && req_valid)
      lru[reqIdx] <= ~hitWay;
  end

  // Pipeline and backing-memory outputs, forced idle in reset
  always_comb begin
    rdata     = '0;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      unique case (state)
        LOOKUP: begin
          stall = req_valid && !anyHit;
          rdata = anyHit ? hitData : '0;
        end
        WRITEBACK: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {vicTag, capIdx, {(OB+2){1'b0}}} |
                      (32'(count) << 2);
          mem_wdata = vicData;
        end
        REFILL: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {capTag, capIdx, {(OB+2){1'b0}}} |
                     (32'(count) << 2);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: directed loads/stores, a
// backing-memory model, and monitors for load data and memory words.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  data_cache dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rdata    (rdata),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rdExp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } memExp_t;

  rdExp_t  rdQ[$];
  memExp_t memQ[$];
  rdExp_t  rdE;
  memExp_t memE;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hCAFE0000;
  endfunction

  // Backing memory: 4K words, pattern-initialised on first edge
  logic [31:0] memArr [4096];
  logic        memInit   = 1'b0;
  int          readyMode = 0;
  logic        phase     = 1'b0;

  assign mem_ready = (readyMode == 0) ? 1'b1 : (mem_req && phase);
  assign mem_rdata = memArr[mem_addr[13:2]];

  always @(posedge clk) begin
    phase <= mem_req ? ~phase : 1'b0;
    if (!memInit) begin
      for (int i = 0; i < 4096; i++)
        memArr[i] <= pat(32'(i) << 2);
      memInit <= 1'b1;
    end else if (mem_req && mem_we && mem_ready) begin
      memArr[mem_addr[13:2]] <= mem_wdata;
    end
  end

  // Monitors: load data on non-stalled loads, every accepted mem word
  always @(negedge clk) begin
    if (!rst && req_valid && !req_write && !stall) begin
      checks++;
      if (rdQ.size() == 0) begin
        failures++;
        $display("FAIL rdata-unexpected got=%h", rdata);
      end else begin
        rdE = rdQ.pop_front();
        if (rdata !== rdE.val) begin
          failures++;
          $display("FAIL %s rdata got=%h exp=%h",
                   rdE.name, rdata, rdE.val);
        end
      end
    end
    if (mem_req && mem_ready) begin
      checks++;
      if (memQ.size() == 0) begin
        failures++;
        $display("FAIL mem-unexpected we=%b addr=%h", mem_we, mem_addr);
      end else begin
        memE = memQ.pop_front();
        if (mem_we !== memE.we || mem_addr !== memE.addr ||
            (memE.we && mem_wdata !== memE.data)) begin
          failures++;
          $display("FAIL mem-word got we=%b addr=%h data=%h exp we=%b addr=%h data=%h",
                   mem_we, mem_addr, mem_wdata,
                   memE.we, memE.addr, memE.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic expReads(input logic [31:0] base);
    for (int i = 0; i < 4; i++)
      memQ.push_back('{1'b0, base + 32'(4 * i), 32'h0});
  endtask

  task automatic expWrites(input logic [31:0] base,
                           input logic [31:0] d0, d1, d2, d3);
    memQ.push_back('{1'b1, base,          d0});
    memQ.push_back('{1'b1, base + 32'h4,  d1});
    memQ.push_back('{1'b1, base + 32'h8,  d2});
    memQ.push_back('{1'b1, base + 32'hC,  d3});
  endtask

  task automatic access(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input int expStall, input logic [31:0] expRd,
                        input string name);
    int n;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = st;
    if (!wr) rdQ.push_back('{name, expRd});
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 60) break;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    checks++;
    if (n != expStall) begin
      failures++;
      $display("FAIL %s stall-cycles got=%0d exp=%0d", name, n, expStall);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h100;
    req_wdata = '0;
    req_wstrb = '0;
    @(negedge clk);
    chk("rst-stall",   32'(stall),   32'h0);
    chk("rst-memreq",  32'(mem_req), 32'h0);
    chk("rst-memwe",   32'(mem_we),  32'h0);
    chk("rst-memaddr", mem_addr,     32'h0);
    chk("rst-rdata",   rdata,        32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst = 1'b0;

    expReads(32'h100);
    access(0, 32'h100, 0, 4'h0, 5, 32'hCAFE0100, "ld100");
    access(1, 32'h104, 32'hDEADBEEF, 4'hF, 0, 0, "st104");
    access(0, 32'h104, 0, 4'h0, 0, 32'hDEADBEEF, "ld104");
    access(1, 32'h108, 32'h11223344, 4'hF, 0, 0, "st108");
    access(1, 32'h108, 32'h000000AA, 4'h1, 0, 0, "st108b0");
    access(0, 32'h108, 0, 4'h0, 0, 32'h112233AA, "ld108a");
    access(1, 32'h108, 32'h00550000, 4'h4, 0, 0, "st108b2");
    access(0, 32'h108, 0, 4'h0, 0, 32'h115533AA, "ld108b");

    expReads(32'h1100);
    access(0, 32'h1100, 0, 4'h0, 5, 32'hCAFE1100, "ld1100");

    expWrites(32'h100, 32'hCAFE0100, 32'hDEADBEEF,
              32'h115533AA, 32'hCAFE010C);
    expReads(32'h2100);
    access(0, 32'h2100, 0, 4'h0, 9, 32'hCAFE2100, "ld2100-wb");

    readyMode = 1;
    expReads(32'h3100);
    access(0, 32'h3100, 0, 4'h0, 9, 32'hCAFE3100, "ld3100-slow");
    readyMode = 0;

    expReads(32'h100);
    access(0, 32'h104, 0, 4'h0, 5, 32'hDEADBEEF, "ld104-mem");

    expReads(32'h3800);
    access(1, 32'h3808, 32'h12345678, 4'hF, 5, 0, "st3808-miss");
    access(0, 32'h3808, 0, 4'h0, 0, 32'h12345678, "ld3808");
    access(0, 32'h3800, 0, 4'h0, 0, 32'hCAFE3800, "ld3800");

    memQ.push_back('{1'b0, 32'h200, 32'h0});
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h200;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("midrst-stall",  32'(stall),   32'h0);
    chk("midrst-memreq", 32'(mem_req), 32'h0);
    chk("midrst-memwe",  32'(mem_we),  32'h0);
    chk("midrst-wdata",  mem_wdata,    32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    expReads(32'h200);
    access(0, 32'h200, 0, 4'h0, 5, 32'hCAFE0200, "ld200-rerefill");
    expReads(32'h100);
    access(0, 32'h104, 0, 4'h0, 5, 32'hDEADBEEF, "ld104-postrst");

    repeat (4) @(posedge clk);
    chk("rdq-drained",  32'(rdQ.size()),  32'h0);
    chk("memq-drained", 32'(memQ.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter SETS, default 64, number of sets, power of two, 2 to 1024.
REQ-002 Parameter WAYS, default 2, associativity, legal values 1 and 2.
REQ-003 Parameter BLOCK_WORDS, default 4, 32-bit words per line, power of two, 1 to 16.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, reset, asynchronous and active-high.
REQ-006 Port req_valid, input, 1, pipeline memory-stage access request.
REQ-007 Port req_write, input, 1, store (1) or load (0).
REQ-008 Port req_addr, input, 32, byte address; bits [1:0] select the byte lane.
REQ-009 Port req_wdata, input, 32, store data, already lane-aligned.
REQ-010 Port req_wstrb, input, 4, store byte enables.
REQ-011 Port rdata, output, 32, load word for the addressed word.
REQ-012 Port stall, output, 1, pipeline freeze request.
REQ-013 Port mem_req, output, 1, backing-memory word request.
REQ-014 Port mem_we, output, 1, backing-memory write.
REQ-015 Port mem_addr, output, 32, word-aligned backing address.
REQ-016 Port mem_wdata, output, 32, write-back data.
REQ-017 Port mem_ready, input, 1, backing-memory word accept / return.
REQ-018 Port mem_rdata, input, 32, refill data, valid when mem_ready is high.

Function
REQ-019 Address split: word offset = log2(BLOCK_WORDS) bits above [1:0], index = log2(SETS) bits above offset, tag = remaining upper bits.
REQ-020 Each line holds valid, dirty, tag and BLOCK_WORDS data words; each set with WAYS=2 holds one LRU bit.
REQ-021 FSM states: LOOKUP, WRITEBACK, REFILL.
REQ-022 LOOKUP hit (valid and tag match): stall=0; rdata is the addressed word, combinational in the same cycle.
REQ-023 A store hit writes the strobed bytes and sets dirty at the clock edge.
REQ-024 Any hit with WAYS=2 sets LRU to point to the way that was not hit.
REQ-025 LOOKUP miss with req_valid: stall=1 in the same cycle; the victim is the invalid way, else the LRU way (way 0 when both ways are invalid).
REQ-026 Miss with a dirty victim goes to WRITEBACK; otherwise it goes to REFILL.
REQ-027 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, word count, 00}, mem_wdata is the victim word; the word counter advances only in a cycle where mem_ready=1.
REQ-028 After the last word of WRITEBACK is accepted: clear the counter and go to REFILL.
REQ-029 REFILL: mem_req=1, mem_we=0, mem_addr={request tag, index, word count, 00}; each mem_ready cycle writes mem_rdata into the victim word at the counter.
REQ-030 After the last word of REFILL is written: set valid=1, dirty=0, write the tag, go to LOOKUP; the replayed request then hits.
REQ-031 stall=1 in WRITEBACK and REFILL.
REQ-032 mem_req=0 in LOOKUP.
REQ-033 Miss latency is (dirty ? BLOCK_WORDS : 0) + BLOCK_WORDS accepted words + 1 lookup cycle.
REQ-034 req_valid=0 in LOOKUP: no state change, stall=0.
REQ-035 The cache SHALL capture the request at the miss edge and use only that captured request until the next LOOKUP.
REQ-036 mem_ready held high continuously SHALL give a throughput of one word per cycle.
REQ-037 mem_ready asserted in LOOKUP SHALL be ignored.

Reset
REQ-038 rst asserted at any time, including mid-WRITEBACK or mid-REFILL, SHALL asynchronously clear all valid, dirty and LRU bits.
REQ-039 rst SHALL force the FSM to LOOKUP and clear the word counter.
REQ-040 rst SHALL drive stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0 and rdata=0.
REQ-041 Data and tag arrays are not reset.
REQ-042 A partially refilled line SHALL remain invalid after reset.

Structure
REQ-043 The shared package holds the FSM state enum, the address-field width functions and the default parameter constants.
REQ-044 One sub-module, cache_way, holds the tag/valid/dirty/data storage of one way and is instantiated WAYS times.

Verification
REQ-045 Reset, then load 0x100 with mem_rdata=addr-based pattern and mem_ready=1 -> stall high 5 cycles, 4 mem reads at 0x100..0x10C, then rdata=pattern(0x100).
REQ-046 Store 0xDEADBEEF to 0x104 with strobe 0xF, then load 0x104 -> no stall, rdata=0xDEADBEEF.
REQ-047 With defaults, touch 0x100, 0x1100 and 0x2100 (same set), 0x100 made dirty -> 4 mem writes at 0x100..0x10C precede 4 refill reads at 0x2100.
REQ-048 Store 0x000000AA with strobe 0x1 to a hit word holding 0x11223344 -> word reads 0x112233AA.
REQ-049 mem_ready toggles every other cycle during refill -> exactly 4 accepted words, stall length 9 cycles.
REQ-050 Assert rst on the second refill word, then reload the same address -> full refill again, no false hit.
